// File: rtl/peripheral_dbg_pu_riscv_pkg.sv
// Shared types and defaults for the debug-unit CDC request scheduler.
package peripheral_dbg_pu_riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int DEF_TIMEOUT = 255;
  localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/peripheral_dbg_pu_riscv_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from
// the slot after the last grant, wrapping at NREQ.
module peripheral_dbg_pu_riscv_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  // One extra bit so last+NREQ never overflows before the wrap subtract.
  logic [IW:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_cand = {1'b0, i_last} + (IW+1)'(i);
      if (w_cand >= (IW+1)'(NREQ)) w_cand = w_cand - (IW+1)'(NREQ);
      if (!o_valid && i_req[w_cand[IW-1:0]]) begin
        o_valid                    = 1'b1;
        o_grant[w_cand[IW-1:0]]    = 1'b1;
        o_idx                      = w_cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/peripheral_dbg_pu_riscv_cdc_req_sched.sv
// Bus-clock side scheduler for toggle-synchronised debug requests: grants one
// pending syncflop at a time, runs the access, and returns a completion toggle.
module peripheral_dbg_pu_riscv_cdc_req_sched
  import peripheral_dbg_pu_riscv_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_req_in,
  output logic [NREQ-1:0] o_req_clr,
  output logic [NREQ-1:0] o_ack_toggle,
  output logic            o_bus_req,
  output logic [IW-1:0]   o_bus_sel,
  input  logic            i_bus_ack,
  input  logic            i_bus_err,
  output logic [NREQ-1:0] o_err_flag,
  input  logic [NREQ-1:0] i_err_clr,
  output logic            o_busy
);

  state_t            r_state, w_state_nxt;
  logic [IW-1:0]     r_last, r_bus_sel;
  logic [CNT_W-1:0]  r_timer;
  logic [NREQ-1:0]   r_ack_toggle, r_err_flag;
  logic              r_bus_req;
  logic [NREQ-1:0]   w_grant, w_req_clr, w_sel_oh;
  logic [IW-1:0]     w_idx;
  logic              w_valid, w_done, w_err;

  peripheral_dbg_pu_riscv_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .i_req   (i_req_in),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  assign w_sel_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_bus_sel;

  always_comb begin
    w_state_nxt = r_state;
    w_req_clr   = '0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_req_clr   = w_grant;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A real ack/err on the expiry cycle takes precedence over the timeout.
        if (i_bus_ack || i_bus_err) begin
          w_done = 1'b1;
          w_err  = i_bus_err;
        end else if (r_timer == CNT_W'(TIMEOUT)) begin
          w_done = 1'b1;
          w_err  = 1'b1;
        end
        if (w_done) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_bus_req    <= 1'b0;
      r_bus_sel    <= '0;
      r_last       <= IW'(NREQ-1);
      r_timer      <= '0;
      r_ack_toggle <= '0;
      r_err_flag   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bus_req <= (w_state_nxt == ST_BUSY);
      if (r_state == ST_IDLE && w_valid) r_bus_sel <= w_idx;
      r_timer <= (r_state == ST_BUSY && !w_done) ? r_timer + CNT_W'(1) : '0;
      if (w_done) begin
        r_ack_toggle <= r_ack_toggle ^ w_sel_oh;
        r_last       <= r_bus_sel;
      end
      // Set beats clear on the same bit.
      r_err_flag <= (r_err_flag & ~i_err_clr) | ((w_done && w_err) ? w_sel_oh : '0);
    end
  end

  assign o_req_clr    = w_req_clr;
  assign o_ack_toggle = r_ack_toggle;
  assign o_bus_req    = r_bus_req;
  assign o_bus_sel    = r_bus_sel;
  assign o_err_flag   = r_err_flag;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_peripheral_dbg_pu_riscv_cdc_req_sched.sv
// Scoreboard bench for the CDC request scheduler: stimulus queues expected
// grants/completions, a negedge monitor pops and compares them.
module tb_peripheral_dbg_pu_riscv_cdc_req_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] i_req = '0;
  logic [1:0] i_err_clr = '0;
  logic       i_bus_ack = 1'b0;
  logic       i_bus_err = 1'b0;
  logic [1:0] o_req_clr, o_ack_toggle, o_err_flag;
  logic       o_bus_req, o_busy;
  logic [0:0] o_bus_sel;

  always #5 clk = ~clk;

  peripheral_dbg_pu_riscv_cdc_req_sched #(.NREQ(2), .CNT_W(8), .TIMEOUT(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_in     (i_req),
    .o_req_clr    (o_req_clr),
    .o_ack_toggle (o_ack_toggle),
    .o_bus_req    (o_bus_req),
    .o_bus_sel    (o_bus_sel),
    .i_bus_ack    (i_bus_ack),
    .i_bus_err    (i_bus_err),
    .o_err_flag   (o_err_flag),
    .i_err_clr    (i_err_clr),
    .o_busy       (o_busy)
  );

  typedef struct packed {
    logic [1:0] tog;
    logic [1:0] err;
  } done_t;

  int    q_grant[$];
  done_t q_done[$];
  int    n_cmp = 0;
  int    n_err = 0;
  logic [1:0] exp_tog = '0;
  logic [1:0] exp_err = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0h expected no event (t=%0t)", name, act, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: grants are seen as REQ_CLR pulses, completions as ACK_TOGGLE changes.
  logic [1:0] prev_tog;
  bit         chk_sel = 1'b0;
  int         sel_exp = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_tog = o_ack_toggle;
      chk_sel  = 1'b0;
    end else begin
      if (chk_sel) begin
        check("bus_req_after_grant", 32'(o_bus_req), 32'd1);
        check("bus_sel", 32'(o_bus_sel), 32'(sel_exp));
        chk_sel = 1'b0;
      end
      if (o_req_clr != 2'b00) begin
        if (q_grant.size() == 0) unexpected("req_clr_unexpected", 32'(o_req_clr));
        else begin
          sel_exp = q_grant.pop_front();
          check("req_clr", 32'(o_req_clr), 32'(1 << sel_exp));
          chk_sel = 1'b1;
        end
      end
      if (o_ack_toggle != prev_tog) begin
        if (q_done.size() == 0) unexpected("ack_toggle_unexpected", 32'(o_ack_toggle));
        else begin
          done_t d;
          d = q_done.pop_front();
          check("ack_toggle", 32'(o_ack_toggle), 32'(d.tog));
          check("err_flag", 32'(o_err_flag), 32'(d.err));
          check("hold_bus_req", 32'(o_bus_req), 32'd0);
          check("hold_busy", 32'(o_busy), 32'd1);
        end
        prev_tog = o_ack_toggle;
      end
    end
  end

  // Called in an IDLE cycle with the requester already pending.
  task automatic run_grant(input int w, input int wait_n, input bit ack, input bit err,
                           input logic [1:0] errclr, input logic [1:0] drop);
    q_grant.push_back(w);
    tick();
    i_req = i_req & ~drop;
    repeat (wait_n) tick();
    i_bus_ack = ack;
    i_bus_err = err;
    i_err_clr = errclr;
    exp_tog[w] = ~exp_tog[w];
    exp_err = exp_err & ~errclr;
    if (err) exp_err[w] = 1'b1;
    q_done.push_back('{tog: exp_tog, err: exp_err});
    tick();
    i_bus_ack = 1'b0;
    i_bus_err = 1'b0;
    i_err_clr = '0;
    tick();
    check("idle_bus_req", 32'(o_bus_req), 32'd0);
    check("idle_busy", 32'(o_busy), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    exp_tog = '0;
    exp_err = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    tick();
    tick();
    check("reset_outputs",
          {22'd0, o_req_clr, o_ack_toggle, o_bus_req, o_bus_sel, o_err_flag, o_busy},
          32'd0);
    rst = 1'b0;

    // Single access from requester 0, acked on the third BUSY cycle.
    i_req = 2'b01;
    run_grant(0, 2, 1'b1, 1'b0, 2'b00, 2'b01);

    // Both requesting continuously: grants alternate 0,1,0,1.
    apply_reset();
    i_req = 2'b11;
    run_grant(0, 1, 1'b1, 1'b0, 2'b00, 2'b00);
    run_grant(1, 1, 1'b1, 1'b0, 2'b00, 2'b00);
    run_grant(0, 1, 1'b1, 1'b0, 2'b00, 2'b00);
    run_grant(1, 1, 1'b1, 1'b0, 2'b00, 2'b00);
    i_req = 2'b00;

    // Error together with ack, then clear, then clear colliding with a new error.
    i_req = 2'b10;
    run_grant(1, 0, 1'b1, 1'b1, 2'b00, 2'b10);
    i_err_clr = 2'b10;
    tick();
    i_err_clr = 2'b00;
    exp_err = 2'b00;
    check("err_clr", 32'(o_err_flag), 32'(exp_err));
    i_req = 2'b10;
    run_grant(1, 1, 1'b0, 1'b1, 2'b10, 2'b10);
    tick();
    check("err_sticky", 32'(o_err_flag), 32'd2);
    i_err_clr = 2'b10;
    tick();
    i_err_clr = 2'b00;
    exp_err = 2'b00;

    // Timeout with no ack: BUS_REQ for TIMEOUT+1 cycles, then error and toggle.
    i_req = 2'b01;
    q_grant.push_back(0);
    exp_tog[0] = ~exp_tog[0];
    exp_err[0] = 1'b1;
    q_done.push_back('{tog: exp_tog, err: exp_err});
    tick();
    i_req = 2'b00;
    cnt = 0;
    for (int k = 0; k < 20 && o_bus_req; k++) begin
      cnt++;
      tick();
    end
    check("timeout_busreq_cycles", 32'(cnt), 32'd5);
    check("timeout_hold_busy", 32'(o_busy), 32'd1);
    tick();
    check("timeout_idle_busy", 32'(o_busy), 32'd0);
    i_err_clr = 2'b01;
    tick();
    i_err_clr = 2'b00;
    exp_err = 2'b00;
    check("timeout_err_clr", 32'(o_err_flag), 32'd0);

    // Ack on the expiry cycle: no error.
    i_req = 2'b01;
    run_grant(0, 4, 1'b1, 1'b0, 2'b00, 2'b01);

    // Reset mid-access.
    i_req = 2'b10;
    run_grant(1, 0, 1'b1, 1'b0, 2'b00, 2'b10);
    i_req = 2'b01;
    q_grant.push_back(0);
    tick();
    i_req = 2'b00;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outputs", {29'd0, o_bus_req, o_busy, o_ack_toggle != 2'b00}, 32'd0);
    exp_tog = '0;
    exp_err = '0;
    i_req = 2'b10;
    tick();
    tick();
    rst = 1'b0;
    run_grant(1, 0, 1'b1, 1'b0, 2'b00, 2'b10);

    // Spurious ack/err in IDLE.
    i_bus_ack = 1'b1;
    i_bus_err = 1'b1;
    tick();
    i_bus_ack = 1'b0;
    i_bus_err = 1'b0;
    tick();
    check("spurious_ack_toggle", 32'(o_ack_toggle), 32'(exp_tog));
    check("spurious_err_flag", 32'(o_err_flag), 32'd0);

    // REQ_IN changes while BUSY are ignored until IDLE.
    i_req = 2'b01;
    q_grant.push_back(0);
    tick();
    i_req = 2'b11;
    tick();
    i_req = 2'b10;
    tick();
    i_bus_ack = 1'b1;
    exp_tog[0] = ~exp_tog[0];
    q_done.push_back('{tog: exp_tog, err: exp_err});
    tick();
    i_bus_ack = 1'b0;
    tick();
    run_grant(1, 0, 1'b1, 1'b0, 2'b00, 2'b10);

    tick();
    tick();
    check("grant_queue_empty", 32'(q_grant.size()), 32'd0);
    check("done_queue_empty", 32'(q_done.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
